// File: rtl/rob_retire_unit_pkg.sv
// Shared retire/ROB core definitions: FSM state encoding, the "no exception"
// code and the number of head slots examined per cycle.
package rob_retire_unit_pkg;

  localparam int SLOTS    = 4;
  localparam int EXC_NONE = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLOCK = 1'b1
  } retire_state_t;

endpackage

// File: rtl/retire_prefix_sel.sv
// Combinational prefix scan over the four oldest ROB entries.
// Ports:
//   i_valid/i_ready/i_break  per-entry flags, bit 0 oldest
//   i_excode                 per-entry exception codes, packed
//   i_hold                   force an empty group with no flush
//   o_count                  entries to retire (0..4)
//   o_term_idx               index of the entry that ended the group
//   o_is_break/o_is_exc      the group ended on a break / an exception
module retire_prefix_sel
  import rob_retire_unit_pkg::*;
#(
  parameter int EXC_W = 6
) (
  input  logic [SLOTS-1:0]       i_valid,
  input  logic [SLOTS-1:0]       i_ready,
  input  logic [SLOTS-1:0]       i_break,
  input  logic [SLOTS*EXC_W-1:0] i_excode,
  input  logic                   i_hold,
  output logic [2:0]             o_count,
  output logic [1:0]             o_term_idx,
  output logic                   o_is_break,
  output logic                   o_is_exc
);

  logic w_done;

  always_comb begin
    o_count    = '0;
    o_term_idx = '0;
    o_is_break = 1'b0;
    o_is_exc   = 1'b0;
    w_done     = i_hold;
    for (int i = 0; i < SLOTS; i++) begin
      if (!w_done) begin
        if (!(i_valid[i] && i_ready[i])) begin
          w_done = 1'b1;
        end else if (i_excode[i*EXC_W +: EXC_W] != EXC_W'(EXC_NONE)) begin
          // exception wins over break and the entry itself does not retire
          o_is_exc   = 1'b1;
          o_term_idx = 2'(i);
          w_done     = 1'b1;
        end else begin
          o_count = 3'(i + 1);
          if (i_break[i]) begin
            o_is_break = 1'b1;
            o_term_idx = 2'(i);
            w_done     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rob_retire_unit.sv
// In-order retire stage behind the ROB. Retires the longest ready prefix of
// the four head entries, frees their destination registers, raises a flush
// on break/exception and blocks retirement for FLUSH_CYCLES after a flush.
// Ports:
//   Clk, Rest                 clock, async active-high reset
//   Head*                     four oldest ROB entries (bit/slice 0 oldest)
//   RetireHold                stall retirement
//   RetireNum                 entries popped by the ROB (registered)
//   RetireReg{1..4}{Able,Addr} register free strobes per slot
//   FlushAble/FlushPtr        one-cycle flush pulse and first discarded ptr
//   ExceptAble/ExceptCode     flush caused by an exception, with its code
//   CommitCount               running count of retired instructions
module rob_retire_unit
  import rob_retire_unit_pkg::*;
#(
  parameter int PTR_W        = 6,
  parameter int PREG_W       = 6,
  parameter int EXC_W        = 6,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic [SLOTS-1:0]        HeadValid,
  input  logic [SLOTS-1:0]        HeadReady,
  input  logic [SLOTS-1:0]        HeadBreak,
  input  logic [SLOTS*EXC_W-1:0]  HeadExcode,
  input  logic [SLOTS-1:0]        HeadDestAble,
  input  logic [SLOTS*PREG_W-1:0] HeadDestPreg,
  input  logic [SLOTS*PTR_W-1:0]  HeadPtr,
  input  logic                    RetireHold,
  output logic [2:0]              RetireNum,
  output logic                    RetireReg1Able,
  output logic                    RetireReg2Able,
  output logic                    RetireReg3Able,
  output logic                    RetireReg4Able,
  output logic [PREG_W-1:0]       RetireReg1Addr,
  output logic [PREG_W-1:0]       RetireReg2Addr,
  output logic [PREG_W-1:0]       RetireReg3Addr,
  output logic [PREG_W-1:0]       RetireReg4Addr,
  output logic                    FlushAble,
  output logic [PTR_W-1:0]        FlushPtr,
  output logic                    ExceptAble,
  output logic [EXC_W-1:0]        ExceptCode,
  output logic [31:0]             CommitCount
);

  retire_state_t r_state, w_state_nxt;
  logic [2:0]    r_blk_cnt, w_blk_cnt_nxt;

  logic [2:0]                   r_num;
  logic [SLOTS-1:0]             r_able;
  logic [SLOTS-1:0][PREG_W-1:0] r_addr;
  logic                         r_flush;
  logic [PTR_W-1:0]             r_flush_ptr;
  logic                         r_exc;
  logic [EXC_W-1:0]             r_exc_code;
  logic [31:0]                  r_commit;

  logic                         w_eval;
  logic                         w_hold;
  logic [2:0]                   w_count;
  logic [1:0]                   w_term_idx;
  logic                         w_is_break;
  logic                         w_is_exc;
  logic                         w_flush;
  logic [PTR_W-1:0]             w_term_ptr;
  logic [PTR_W-1:0]             w_flush_ptr;
  logic [EXC_W-1:0]             w_exc_code;
  logic [SLOTS-1:0]             w_able;
  logic [SLOTS-1:0][PREG_W-1:0] w_addr;

  // The cycle after a non-zero pop the head inputs are stale, so skip it.
  assign w_eval = (r_state == ST_RUN) && (r_num == 3'd0);
  assign w_hold = RetireHold || !w_eval;

  retire_prefix_sel #(
    .EXC_W (EXC_W)
  ) u_prefix_sel (
    .i_valid    (HeadValid),
    .i_ready    (HeadReady),
    .i_break    (HeadBreak),
    .i_excode   (HeadExcode),
    .i_hold     (w_hold),
    .o_count    (w_count),
    .o_term_idx (w_term_idx),
    .o_is_break (w_is_break),
    .o_is_exc   (w_is_exc)
  );

  assign w_flush     = w_is_break || w_is_exc;
  assign w_term_ptr  = HeadPtr[w_term_idx*PTR_W +: PTR_W];
  // a break retires its own entry, so discarding starts one past it (wraps)
  assign w_flush_ptr = !w_flush   ? '0 :
                       w_is_break ? w_term_ptr + PTR_W'(1) : w_term_ptr;
  assign w_exc_code  = w_is_exc ? HeadExcode[w_term_idx*EXC_W +: EXC_W] : '0;

  always_comb begin
    w_able = '0;
    w_addr = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if ((3'(k) < w_count) && HeadDestAble[k]) begin
        w_able[k] = 1'b1;
        w_addr[k] = HeadDestPreg[k*PREG_W +: PREG_W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_state   <= ST_RUN;
      r_blk_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt   = r_state;
    w_blk_cnt_nxt = r_blk_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_flush) begin
          w_state_nxt   = ST_BLOCK;
          w_blk_cnt_nxt = 3'(FLUSH_CYCLES);
        end
      end
      ST_BLOCK: begin
        if (r_blk_cnt <= 3'd1) begin
          w_state_nxt   = ST_RUN;
          w_blk_cnt_nxt = '0;
        end else begin
          w_blk_cnt_nxt = r_blk_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt   = ST_RUN;
        w_blk_cnt_nxt = '0;
      end
    endcase
  end

  // Output registers: everything below is zero unless this cycle evaluated.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_num       <= '0;
      r_able      <= '0;
      r_addr      <= '0;
      r_flush     <= 1'b0;
      r_flush_ptr <= '0;
      r_exc       <= 1'b0;
      r_exc_code  <= '0;
      r_commit    <= '0;
    end else begin
      r_num       <= w_count;
      r_able      <= w_able;
      r_addr      <= w_addr;
      r_flush     <= w_flush;
      r_flush_ptr <= w_flush_ptr;
      r_exc       <= w_is_exc;
      r_exc_code  <= w_exc_code;
      r_commit    <= r_commit + 32'(w_count);
    end
  end

  assign RetireNum      = r_num;
  assign RetireReg1Able = r_able[0];
  assign RetireReg2Able = r_able[1];
  assign RetireReg3Able = r_able[2];
  assign RetireReg4Able = r_able[3];
  assign RetireReg1Addr = r_addr[0];
  assign RetireReg2Addr = r_addr[1];
  assign RetireReg3Addr = r_addr[2];
  assign RetireReg4Addr = r_addr[3];
  assign FlushAble      = r_flush;
  assign FlushPtr       = r_flush_ptr;
  assign ExceptAble     = r_exc;
  assign ExceptCode     = r_exc_code;
  assign CommitCount    = r_commit;

endmodule
